// File: rtl/vga_pixel_scanout.sv
// VGA scan-out stage: consumes a valid/ready RGB pixel stream and drives the
// DE1-SoC VGA DAC with 640x480@60 timing from CLOCK_50 using an
// every-other-cycle pixel enable. Locks to the stream's start-of-frame marker
// and falls back to resynchronising at the next frame on underflow or a
// misplaced/missing start-of-frame.
//
// Handshake: a beat transfers in a cycle where in_valid & in_ready are both 1.
// in_data/in_sop must be held stable while in_valid=1 and in_ready=0.
// in_ready may depend combinationally on in_valid/in_sop, so upstream must not
// derive in_valid from in_ready.
module vga_pixel_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [3*COLOR_W-1:0]   in_data,
  input  logic                   in_sop,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic                   VGA_CLK,
  output logic                   frame_start,
  output logic                   underflow,
  output logic                   sync_err,
  output logic                   state_dbg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_LAST_C = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] HS_BEG_C = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END_C = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_LAST_C = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] VS_BEG_C = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END_C = V_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_RESYNC = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 pix_en;
  logic                 fresh;
  logic [H_W-1:0]       h_cnt;
  logic [V_W-1:0]       v_cnt;

  logic                 active;
  logic                 at_origin;
  logic                 frame_wrap;
  logic                 hs_on;
  logic                 vs_on;
  logic                 take;
  logic                 set_uf;
  logic                 set_se;
  logic [3*COLOR_W-1:0] rgb_nxt;

  assign active     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign at_origin  = pix_en && (h_cnt == '0) && (v_cnt == '0);
  assign frame_wrap = (h_cnt == H_LAST_C) && (v_cnt == V_LAST_C);
  assign hs_on      = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
  assign vs_on      = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
  assign rgb_nxt    = take ? in_data : '0;

  // The DAC latches on VGA_CLK rising, which lands mid-way through each
  // two-cycle output pixel because the outputs change as pix_en falls.
  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b0;
  assign state_dbg  = state;

  // Pixel enable and raster counters; counters step only on pix_en cycles.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pix_en <= 1'b0;
      fresh  <= 1'b1;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      fresh  <= 1'b0;
      if (pix_en) begin
        if (h_cnt == H_LAST_C) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST_C) begin
            v_cnt <= '0;
          end else begin
            v_cnt <= v_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Lock state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_RESYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake and pixel-take decisions.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    take      = 1'b0;
    set_uf    = 1'b0;
    set_se    = 1'b0;
    if (!reset) begin
      case (state)
        ST_RESYNC: begin
          // Junk beats drain at full clock rate; an sop beat waits for (0,0).
          if (in_valid && !in_sop) begin
            in_ready = 1'b1;
          end else if (in_valid && in_sop && at_origin) begin
            in_ready  = 1'b1;
            take      = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pix_en && active) begin
            if (!in_valid) begin
              in_ready  = 1'b1;
              set_uf    = 1'b1;
              state_nxt = ST_RESYNC;
            end else if (in_sop && !at_origin) begin
              // Early sop is left on the bus to start the next frame.
              set_se    = 1'b1;
              state_nxt = ST_RESYNC;
            end else if (!in_sop && at_origin) begin
              in_ready  = 1'b1;
              set_se    = 1'b1;
              state_nxt = ST_RESYNC;
            end else begin
              in_ready = 1'b1;
              take     = 1'b1;
            end
          end
        end
        default: state_nxt = ST_RESYNC;
      endcase
    end
  end

  // Registered DAC outputs, updated at the end of each pix_en cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_en) begin
      VGA_R       <= rgb_nxt[3*COLOR_W-1 -: COLOR_W];
      VGA_G       <= rgb_nxt[2*COLOR_W-1 -: COLOR_W];
      VGA_B       <= rgb_nxt[COLOR_W-1:0];
      VGA_HS      <= ~hs_on;
      VGA_VS      <= ~vs_on;
      VGA_BLANK_N <= active;
    end
  end

  // Frame pulse after the raster wraps, plus once right after reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= (pix_en && frame_wrap) || fresh;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      if (set_uf) underflow <= 1'b1;
      if (set_se) sync_err  <= 1'b1;
    end
  end

endmodule
